// File: rtl/klp32_mc_ctrl.sv
// klp32_mc_ctrl: multi-cycle control FSM and PC/IR sequencer for the KLP32 core.
// Fetch and load/store share one ready/valid memory port. Control outputs are
// decoded from the registered IR and the FSM state only, so there is never a
// combinational path from mem_rdata to the datapath controls.
// Optional feature: define KLP32_RETIRE_CNT_EN to build the 64-bit retired
// instruction counter on instret; when undefined, instret is constant zero.
module klp32_mc_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic [XLEN-1:0] alu_out,
  input  logic            BrEq,
  input  logic            BrLT,
  output logic [XLEN-1:0] pc_out,
  output logic [31:0]     ir_out,
  output logic            RegWEn,
  output logic            ALUsrc1,
  output logic            ALUsrc2,
  output logic            BrUn,
  output logic            ldU,
  output logic [2:0]      immSel,
  output logic [3:0]      aluSel,
  output logic [1:0]      wb_select,
  output logic            halted,
  output logic [63:0]     instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] WB_MEM = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [31:0]     NOP     = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic            taken_q, taken_d;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_jal, is_jalr, is_branch, is_load, is_store, writes_rd;
  logic            ctrl_active;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] next_pc;

  // RV32I base encodings this sequencer executes. SYSTEM (ECALL, EBREAK and
  // CSR accesses) is deliberately absent so it lands in HALT with the rest.
  function automatic logic insn_legal(input logic [31:0] insn);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       ok;
    op = insn[6:0];
    f3 = insn[14:12];
    f7 = insn[31:25];
    ok = 1'b0;
    case (op)
      OPC_LUI, OPC_AUIPC, OPC_JAL: ok = 1'b1;
      OPC_JALR:   ok = (f3 == 3'b000);
      OPC_BRANCH: ok = (f3 != 3'b010) && (f3 != 3'b011);
      OPC_LOAD:   ok = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
      OPC_STORE:  ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
      OPC_OPIMM: begin
        case (f3)
          3'b001:  ok = (f7 == 7'h00);
          3'b101:  ok = (f7 == 7'h00) || (f7 == 7'h20);
          default: ok = 1'b1;
        endcase
      end
      OPC_OP:   ok = (f7 == 7'h00) ||
                     ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)));
      OPC_MISC: ok = (f3 == 3'b000);
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Branch condition; BrLT already reflects signedness chosen through BrUn.
  function automatic logic branch_taken(input logic [2:0] f3, input logic eq,
                                        input logic lt);
    logic t;
    case (f3)
      3'b000:          t = eq;
      3'b001:          t = !eq;
      3'b100, 3'b110:  t = lt;
      3'b101, 3'b111:  t = !lt;
      default:         t = 1'b0;
    endcase
    return t;
  endfunction

  assign opcode    = ir_q[6:0];
  assign funct3    = ir_q[14:12];
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign writes_rd = (opcode == OPC_OP)  || (opcode == OPC_OPIMM) || is_load ||
                     (opcode == OPC_LUI) || (opcode == OPC_AUIPC) || is_jal  ||
                     is_jalr;

  // Datapath controls stay valid from DECODE through WB so alu_out still
  // carries the branch/jump target when the PC is written in WB.
  assign ctrl_active = (state_q == S_DECODE) || (state_q == S_EXEC) ||
                       (state_q == S_MEM)    || (state_q == S_WB);

  assign pc_out = pc_q;
  assign ir_out = ir_q;
  assign halted = (state_q == S_HALT);

  // Decode the latched instruction into ALU, immediate and writeback selects.
  always_comb begin
    ALUsrc1   = 1'b0;
    ALUsrc2   = 1'b0;
    BrUn      = 1'b0;
    ldU       = 1'b0;
    immSel    = IMM_I;
    aluSel    = 4'b0000;
    wb_select = WB_MEM;
    if (ctrl_active) begin
      wb_select = WB_ALU;
      case (opcode)
        OPC_OP: begin
          aluSel = {ir_q[30], funct3};
        end
        OPC_OPIMM: begin
          ALUsrc2 = 1'b1;
          aluSel  = {(funct3 == 3'b101) ? ir_q[30] : 1'b0, funct3};
        end
        OPC_LUI: begin
          ALUsrc2 = 1'b1;
          immSel  = IMM_U;
        end
        OPC_AUIPC: begin
          ALUsrc1 = 1'b1;
          ALUsrc2 = 1'b1;
          immSel  = IMM_U;
        end
        OPC_JAL: begin
          ALUsrc1   = 1'b1;
          ALUsrc2   = 1'b1;
          immSel    = IMM_J;
          wb_select = WB_PC4;
        end
        OPC_JALR: begin
          ALUsrc2   = 1'b1;
          wb_select = WB_PC4;
        end
        OPC_BRANCH: begin
          ALUsrc1 = 1'b1;
          ALUsrc2 = 1'b1;
          immSel  = IMM_B;
          BrUn    = funct3[1];
        end
        OPC_LOAD: begin
          ALUsrc2   = 1'b1;
          ldU       = funct3[2];
          wb_select = WB_MEM;
        end
        OPC_STORE: begin
          ALUsrc2 = 1'b1;
          immSel  = IMM_S;
        end
        default: begin
          ALUsrc2 = 1'b1;
        end
      endcase
    end
  end

  // Next sequential PC: JALR clears bit 0, taken branch/JAL use the ALU target.
  always_comb begin
    pc_plus4 = pc_q + PC_STEP;
    if (is_jalr) begin
      next_pc = {alu_out[XLEN-1:1], 1'b0};
    end else if (is_jal || (is_branch && taken_q)) begin
      next_pc = alu_out;
    end else begin
      next_pc = pc_plus4;
    end
  end

  // Next-state logic, IR/PC capture and memory-port drive.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    taken_d  = taken_q;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = pc_q;
    RegWEn   = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_d    = mem_rdata[31:0];
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = insn_legal(ir_q) ? S_EXEC : S_HALT;
      end
      S_EXEC: begin
        taken_d = is_branch && branch_taken(funct3, BrEq, BrLT);
        state_d = (is_load || is_store) ? S_MEM : S_WB;
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_we   = is_store;
        mem_addr = alu_out;
        if (mem_ready) begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        RegWEn = writes_rd;
        if (next_pc[1:0] != 2'b00) begin
          state_d = S_HALT;
        end else begin
          pc_d    = next_pc;
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
    // A request in flight is dropped immediately so a pending store never
    // completes once reset is seen.
    if (reset) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
    end
  end

  // State, PC, IR and branch-outcome registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= NOP;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      taken_q <= taken_d;
    end
  end

`ifdef KLP32_RETIRE_CNT_EN
  logic [63:0] instret_q, instret_d;

  // One count per WB cycle; HALT never passes through WB so it freezes.
  always_comb begin
    instret_d = instret_q;
    if (state_q == S_WB) begin
      instret_d = instret_q + 64'd1;
    end
  end

  // Retired-instruction counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      instret_q <= 64'd0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;
`else
  assign instret = 64'd0;
`endif

endmodule

// File: tb/tb_klp32_mc_ctrl.sv
// tb_klp32_mc_ctrl: directed and randomized bench for klp32_mc_ctrl.
// A behavioural model predicts per-cycle port activity and the architectural
// PC / halt / retire state of each instruction from its class.
module tb_klp32_mc_ctrl;

  localparam logic [31:0] RPC = 32'h0000_0100;

`ifdef KLP32_RETIRE_CNT_EN
  localparam bit RET_EN = 1'b1;
`else
  localparam bit RET_EN = 1'b0;
`endif

  localparam int C_OP    = 0;
  localparam int C_OPIMM = 1;
  localparam int C_LUI   = 2;
  localparam int C_AUIPC = 3;
  localparam int C_JAL   = 4;
  localparam int C_JALR  = 5;
  localparam int C_BR    = 6;
  localparam int C_LOAD  = 7;
  localparam int C_STORE = 8;
  localparam int C_STOP  = 9;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, mem_ready = 1'b0;
  logic [31:0] mem_addr, mem_rdata = 32'h0, alu_out = 32'h0;
  logic        BrEq = 1'b0, BrLT = 1'b0;
  logic [31:0] pc_out, ir_out;
  logic        RegWEn, ALUsrc1, ALUsrc2, BrUn, ldU, halted;
  logic [2:0]  immSel;
  logic [3:0]  aluSel;
  logic [1:0]  wb_select;
  logic [63:0] instret;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_pc = RPC;
  logic        m_halt = 1'b0;
  logic [63:0] m_ret = 64'd0;

  always #5 clk = ~clk;

  klp32_mc_ctrl #(.XLEN(32), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .alu_out(alu_out), .BrEq(BrEq), .BrLT(BrLT), .pc_out(pc_out),
    .ir_out(ir_out), .RegWEn(RegWEn), .ALUsrc1(ALUsrc1), .ALUsrc2(ALUsrc2),
    .BrUn(BrUn), .ldU(ldU), .immSel(immSel), .aluSel(aluSel),
    .wb_select(wb_select), .halted(halted), .instret(instret)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit cls_writes(input int cls);
    return cls inside {C_OP, C_OPIMM, C_LUI, C_AUIPC, C_JAL, C_JALR, C_LOAD};
  endfunction

  // {ALUsrc1, ALUsrc2, immSel, aluSel, BrUn, ldU} expected for a class.
  function automatic logic [10:0] exp_ctrl(input int cls, input logic [31:0] insn);
    logic s1, s2, bu, lu;
    logic [2:0] im, f3;
    logic [3:0] as;
    f3 = insn[14:12];
    s1 = 1'b0; s2 = 1'b1; bu = 1'b0; lu = 1'b0; im = 3'd0; as = 4'd0;
    case (cls)
      C_OP:    begin s2 = 1'b0; as = {insn[30], f3}; end
      C_OPIMM: as = {(f3 == 3'd5) ? insn[30] : 1'b0, f3};
      C_LUI:   im = 3'd3;
      C_AUIPC: begin s1 = 1'b1; im = 3'd3; end
      C_JAL:   begin s1 = 1'b1; im = 3'd4; end
      C_BR:    begin s1 = 1'b1; im = 3'd2; bu = f3[1]; end
      C_LOAD:  lu = f3[2];
      C_STORE: im = 3'd1;
      default: ;
    endcase
    return {s1, s2, im, as, bu, lu};
  endfunction

  function automatic logic [31:0] gen_insn(input int cls);
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [11:0] imm;
    logic [31:0] w;
    rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    imm = 12'($urandom); f3 = 3'($urandom);
    case (cls)
      C_OP: begin
        f7 = (((f3 == 3'd0) || (f3 == 3'd5)) && ($urandom_range(0, 1) == 1)) ? 7'h20 : 7'h00;
        w = {f7, rs2, rs1, f3, rd, 7'b0110011};
      end
      C_OPIMM: begin
        if (f3 == 3'd1) imm[11:5] = 7'h00;
        if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        w = {imm, rs1, f3, rd, 7'b0010011};
      end
      C_LUI:   w = {20'($urandom), rd, 7'b0110111};
      C_AUIPC: w = {20'($urandom), rd, 7'b0010111};
      C_JAL:   w = {20'($urandom), rd, 7'b1101111};
      C_JALR:  w = {imm, rs1, 3'b000, rd, 7'b1100111};
      C_BR: begin
        case ($urandom_range(0, 5))
          0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd4;
          3: f3 = 3'd5; 4: f3 = 3'd6; default: f3 = 3'd7;
        endcase
        w = {7'($urandom), rs2, rs1, f3, 5'($urandom), 7'b1100011};
      end
      C_LOAD: begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
        endcase
        w = {imm, rs1, f3, rd, 7'b0000011};
      end
      C_STORE: begin
        f3 = 3'($urandom_range(0, 2));
        w = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
      end
      default: begin
        case ($urandom_range(0, 2))
          0: w = 32'hFFFF_FFFF;
          1: w = 32'h0000_0073;
          default: w = 32'h0010_0073;
        endcase
      end
    endcase
    return w;
  endfunction

  // Holds reset for n cycles (n >= 2); called at posedge+1.
  task automatic do_reset(input int n);
    reset = 1'b1; mem_ready = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      chk("rst_mem_req", 64'(mem_req), 64'(0));
      chk("rst_mem_we", 64'(mem_we), 64'(0));
      if (c >= 1) begin
        chk("rst_pc", 64'(pc_out), 64'(RPC));
        chk("rst_ir", 64'(ir_out), 64'h13);
        chk("rst_ctrl", 64'({RegWEn, ALUsrc1, ALUsrc2, BrUn, ldU, immSel, aluSel, wb_select}), 64'(0));
        chk("rst_halted", 64'(halted), 64'(0));
        chk("rst_instret", instret, 64'(0));
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    m_pc = RPC; m_halt = 1'b0; m_ret = 64'd0;
  endtask

  // Runs one instruction from FETCH; abort_at >= 0 stops after that cycle.
  task automatic run_instr(input logic [31:0] insn, input int cls, input int fw,
                           input int mw, input logic [31:0] alu, input logic eq,
                           input logic lt, input int abort_at);
    bit memop, stop, taken, in_f, in_m;
    int exe_c, mem_s, mem_e, wb_c, total;
    logic [2:0] f3;
    logic [31:0] nxt;
    memop = (cls == C_LOAD) || (cls == C_STORE);
    stop  = (cls == C_STOP);
    f3 = insn[14:12];
    exe_c = fw + 2; mem_s = fw + 3;
    mem_e = memop ? fw + 3 + mw : fw + 2;
    wb_c  = mem_e + 1;
    total = stop ? fw + 2 : wb_c + 1;
    case (f3)
      3'd0: taken = eq;
      3'd1: taken = !eq;
      3'd4, 3'd6: taken = lt;
      default: taken = !lt;
    endcase
    if (cls == C_JALR) nxt = {alu[31:1], 1'b0};
    else if ((cls == C_JAL) || ((cls == C_BR) && taken)) nxt = alu;
    else nxt = m_pc + 32'd4;
    alu_out = alu; BrEq = eq; BrLT = lt;
    for (int c = 0; c < total; c++) begin
      in_f = (c <= fw);
      in_m = memop && (c >= mem_s) && (c <= mem_e);
      if (in_f) mem_ready = (c == fw);
      else if (in_m) mem_ready = (c == mem_e);
      else mem_ready = 1'($urandom);
      mem_rdata = (c == fw) ? insn : $urandom();
      @(negedge clk);
      chk("mem_req", 64'(mem_req), 64'(in_f || in_m));
      chk("mem_we", 64'(mem_we), 64'(in_m && (cls == C_STORE)));
      if (in_f) chk("fetch_addr", 64'(mem_addr), 64'(m_pc));
      if (in_m) chk("data_addr", 64'(mem_addr), 64'(alu));
      chk("RegWEn", 64'(RegWEn), 64'(!stop && (c == wb_c) && cls_writes(cls)));
      chk("halted_run", 64'(halted), 64'(0));
      if (!stop && (c == exe_c))
        chk("ctrl", 64'({ALUsrc1, ALUsrc2, immSel, aluSel, BrUn, ldU}), 64'(exp_ctrl(cls, insn)));
      if (!stop && (c == wb_c) && cls_writes(cls))
        chk("wb_select", 64'(wb_select),
            64'((cls == C_LOAD) ? 2'd0 : ((cls == C_JAL) || (cls == C_JALR)) ? 2'd2 : 2'd1));
      @(posedge clk); #1;
      if (c == abort_at) return;
    end
    mem_ready = 1'b0;
    if (stop) begin
      m_halt = 1'b1;
    end else begin
      m_ret = m_ret + 64'd1;
      if (nxt[1:0] != 2'b00) m_halt = 1'b1;
      else m_pc = nxt;
    end
    chk("pc", 64'(pc_out), 64'(m_pc));
    chk("ir", 64'(ir_out), 64'(insn));
    chk("halted", 64'(halted), 64'(m_halt));
    chk("instret", instret, RET_EN ? m_ret : 64'd0);
  endtask

  task automatic idle_halt(input int n);
    for (int c = 0; c < n; c++) begin
      mem_ready = 1'($urandom); mem_rdata = $urandom();
      @(negedge clk);
      chk("halt_mem_req", 64'(mem_req), 64'(0));
      chk("halt_RegWEn", 64'(RegWEn), 64'(0));
      chk("halt_sticky", 64'(halted), 64'(1));
      chk("halt_pc", 64'(pc_out), 64'(m_pc));
      chk("halt_instret", instret, RET_EN ? m_ret : 64'd0);
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
  endtask

  initial begin
    int cls, fw, mw;
    logic [31:0] alu;
    // Reset held three cycles, then first fetch at RESET_PC.
    do_reset(3);
    // ADDI x1,x0,5: RegWEn in cycle 4, PC 0x104 in cycle 5.
    run_instr(32'h0050_0093, C_OPIMM, 0, 0, 32'h5, 1'b0, 1'b0, -1);
    // LW x2,0(x1) with two memory wait states: 7 cycles.
    run_instr(32'h0000_A103, C_LOAD, 0, 2, 32'h200, 1'b0, 1'b0, -1);
    // BEQ taken to 0x80, BEQ not taken, BLTU taken with BrUn.
    run_instr(32'h0000_8063, C_BR, 0, 0, 32'h80, 1'b1, 1'b0, -1);
    run_instr(32'h0000_8063, C_BR, 1, 0, 32'h200, 1'b0, 1'b1, -1);
    run_instr(32'h0000_E063, C_BR, 0, 0, 32'h40, 1'b0, 1'b1, -1);
    // JAL to the top of memory, then sequential wrap to 0.
    run_instr(32'h0000_006F, C_JAL, 0, 0, 32'hFFFF_FFFC, 1'b0, 1'b0, -1);
    run_instr(32'h0050_0093, C_OPIMM, 2, 0, 32'h5, 1'b0, 1'b0, -1);
    // JALR clears bit 0 of the target.
    run_instr(32'h0000_80E7, C_JALR, 0, 0, 32'h0000_0301, 1'b0, 1'b0, -1);
    // Illegal word, ECALL and EBREAK halt after DECODE.
    run_instr(32'hFFFF_FFFF, C_STOP, 1, 0, 32'h0, 1'b0, 1'b0, -1);
    idle_halt(20);
    do_reset(2);
    run_instr(32'h0000_0073, C_STOP, 0, 0, 32'h0, 1'b0, 1'b0, -1);
    idle_halt(3);
    do_reset(2);
    run_instr(32'h0010_0073, C_STOP, 0, 0, 32'h0, 1'b0, 1'b0, -1);
    idle_halt(3);
    do_reset(2);
    // Taken BNE to a misaligned target halts with the PC unchanged.
    run_instr(32'h0000_9063, C_BR, 0, 0, 32'h0000_0102, 1'b0, 1'b0, -1);
    idle_halt(5);
    do_reset(2);
    // Reset during a fetch wait, then fetch restarts at RESET_PC.
    mem_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      mem_rdata = $urandom();
      @(negedge clk);
      chk("fwait_req", 64'(mem_req), 64'(1));
      chk("fwait_addr", 64'(mem_addr), 64'(m_pc));
      @(posedge clk); #1;
    end
    do_reset(2);
    run_instr(32'h0050_0093, C_OPIMM, 0, 0, 32'h5, 1'b0, 1'b0, -1);
    // Reset during a store wait state drops the request.
    run_instr(32'h0020_A023, C_STORE, 0, 3, 32'h300, 1'b0, 1'b0, 4);
    do_reset(2);
    // Randomized instruction stream.
    for (int i = 0; i < 160; i++) begin
      cls = $urandom_range(0, 8);
      if ($urandom_range(0, 19) == 0) cls = C_STOP;
      fw = $urandom_range(0, 2);
      mw = $urandom_range(0, 2);
      alu = $urandom() & 32'hFFFF_FFFC;
      if (cls == C_JALR) alu[0] = 1'($urandom);
      if ((cls == C_BR) && ($urandom_range(0, 9) == 0)) alu[1] = 1'b1;
      run_instr(gen_insn(cls), cls, fw, mw, alu, 1'($urandom), 1'($urandom), -1);
      if (m_halt) begin
        idle_halt(4);
        do_reset(2);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
